// File: rtl/morra_cinese_match.sv
// Two-player Morra Cinese match engine: referees rounds, applies the repeat-winning-move
// void rule, tracks advantage and ends the match. Optional MORRA_SCORE_EN adds win/draw tallies.
module morra_cinese_match #(
    parameter int MIN_ROUNDS = 4,
    parameter int WIN_MARGIN = 2,
    parameter int MAX_VOID   = 3,
    parameter int CNT_W      = 5,
    localparam int ADV_W     = $clog2(WIN_MARGIN + 1) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    START,
    input  logic [1:0]              P1,
    input  logic [1:0]              P2,
    input  logic                    MOVE_VALID,
    output logic [1:0]              ROUND,
    output logic                    ROUND_VALID,
    output logic [1:0]              GAME,
    output logic [CNT_W-1:0]        PLAYED,
    output logic signed [ADV_W-1:0] ADV
`ifdef MORRA_SCORE_EN
    ,
    output logic [CNT_W-1:0]        P1_WINS,
    output logic [CNT_W-1:0]        P2_WINS,
    output logic [CNT_W-1:0]        DRAWS
`endif
);

    localparam int VC_W = $clog2(MAX_VOID + 1);

    localparam logic [1:0] MV_NONE  = 2'b00;
    localparam logic [1:0] ROCK     = 2'b01;
    localparam logic [1:0] PAPER    = 2'b10;
    localparam logic [1:0] SCISSORS = 2'b11;

    localparam logic [1:0] RES_VOID = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic signed [ADV_W-1:0] ADV_ZERO = ADV_W'(0);
    localparam logic signed [ADV_W-1:0] ADV_ONE  = ADV_W'(1);
    localparam logic signed [ADV_W-1:0] WM_POS   = ADV_W'(WIN_MARGIN);
    localparam logic signed [ADV_W-1:0] WM_NEG   = -WM_POS;
    localparam logic [VC_W-1:0]         VC_MAX   = VC_W'(MAX_VOID);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return ((a == ROCK) && (b == SCISSORS)) ||
               ((a == PAPER) && (b == ROCK)) ||
               ((a == SCISSORS) && (b == PAPER));
    endfunction

    state_e                  state_q, state_d;
    logic [1:0]              round_q, round_d;
    logic                    round_valid_q, round_valid_d;
    logic [1:0]              game_q, game_d;
    logic [CNT_W-1:0]        played_q, played_d;
    logic signed [ADV_W-1:0] adv_q, adv_d;
    logic [CNT_W-1:0]        to_play_q, to_play_d;
    logic [VC_W-1:0]         void_cnt_q, void_cnt_d;
    logic [1:0]              prev_win_q, prev_win_d;
    logic [1:0]              prev_move_q, prev_move_d;
    logic                    is_void_s;
`ifdef MORRA_SCORE_EN
    logic [CNT_W-1:0]        p1_wins_q, p1_wins_d;
    logic [CNT_W-1:0]        p2_wins_q, p2_wins_d;
    logic [CNT_W-1:0]        draws_q, draws_d;
`endif

    // A round is void on a missing move or when the previous winner repeats its winning move
    always_comb begin
        is_void_s = (P1 == MV_NONE) || (P2 == MV_NONE) ||
                    ((prev_win_q == WIN_P1) && (P1 == prev_move_q)) ||
                    ((prev_win_q == WIN_P2) && (P2 == prev_move_q));
    end

    // Next-state: START restart, round scoring and end-of-match decision
    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        round_valid_d = 1'b0;
        game_d        = game_q;
        played_d      = played_q;
        adv_d         = adv_q;
        to_play_d     = to_play_q;
        void_cnt_d    = void_cnt_q;
        prev_win_d    = prev_win_q;
        prev_move_d   = prev_move_q;
`ifdef MORRA_SCORE_EN
        p1_wins_d     = p1_wins_q;
        p2_wins_d     = p2_wins_q;
        draws_d       = draws_q;
`endif
        if (START) begin
            state_d     = S_PLAY;
            round_d     = RES_VOID;
            game_d      = 2'b00;
            played_d    = {CNT_W{1'b0}};
            adv_d       = ADV_ZERO;
            to_play_d   = CNT_W'({P1, P2}) + CNT_W'(MIN_ROUNDS);
            void_cnt_d  = {VC_W{1'b0}};
            prev_win_d  = WIN_NONE;
            prev_move_d = MV_NONE;
`ifdef MORRA_SCORE_EN
            p1_wins_d   = {CNT_W{1'b0}};
            p2_wins_d   = {CNT_W{1'b0}};
            draws_d     = {CNT_W{1'b0}};
`endif
        end else if ((state_q == S_PLAY) && MOVE_VALID) begin
            round_valid_d = 1'b1;
            if (is_void_s) begin
                round_d    = RES_VOID;
                void_cnt_d = void_cnt_q + VC_W'(1);
            end else begin
                played_d   = played_q + CNT_W'(1);
                void_cnt_d = {VC_W{1'b0}};
                if (beats(P1, P2)) begin
                    round_d     = RES_P1;
                    adv_d       = adv_q + ADV_ONE;
                    prev_win_d  = WIN_P1;
                    prev_move_d = P1;
`ifdef MORRA_SCORE_EN
                    p1_wins_d   = p1_wins_q + CNT_W'(1);
`endif
                end else if (beats(P2, P1)) begin
                    round_d     = RES_P2;
                    adv_d       = adv_q - ADV_ONE;
                    prev_win_d  = WIN_P2;
                    prev_move_d = P2;
`ifdef MORRA_SCORE_EN
                    p2_wins_d   = p2_wins_q + CNT_W'(1);
`endif
                end else begin
                    round_d     = RES_DRAW;
                    prev_win_d  = WIN_NONE;
                    prev_move_d = MV_NONE;
`ifdef MORRA_SCORE_EN
                    draws_d     = draws_q + CNT_W'(1);
`endif
                end
            end
            // End check is evaluated on the post-round values
            if (adv_d >= WM_POS) begin
                game_d = 2'b01;
            end else if (adv_d <= WM_NEG) begin
                game_d = 2'b10;
            end else if (played_d == to_play_q) begin
                if (adv_d > ADV_ZERO) begin
                    game_d = 2'b01;
                end else if (adv_d < ADV_ZERO) begin
                    game_d = 2'b10;
                end else begin
                    game_d = 2'b11;
                end
            end else if (void_cnt_d == VC_MAX) begin
                game_d = 2'b11;
            end else begin
                game_d = 2'b00;
            end
            if (game_d != 2'b00) begin
                state_d = S_DONE;
            end else begin
                state_d = S_PLAY;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            round_q       <= RES_VOID;
            round_valid_q <= 1'b0;
            game_q        <= 2'b00;
            played_q      <= {CNT_W{1'b0}};
            adv_q         <= ADV_ZERO;
            to_play_q     <= {CNT_W{1'b0}};
            void_cnt_q    <= {VC_W{1'b0}};
            prev_win_q    <= WIN_NONE;
            prev_move_q   <= MV_NONE;
`ifdef MORRA_SCORE_EN
            p1_wins_q     <= {CNT_W{1'b0}};
            p2_wins_q     <= {CNT_W{1'b0}};
            draws_q       <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            round_valid_q <= round_valid_d;
            game_q        <= game_d;
            played_q      <= played_d;
            adv_q         <= adv_d;
            to_play_q     <= to_play_d;
            void_cnt_q    <= void_cnt_d;
            prev_win_q    <= prev_win_d;
            prev_move_q   <= prev_move_d;
`ifdef MORRA_SCORE_EN
            p1_wins_q     <= p1_wins_d;
            p2_wins_q     <= p2_wins_d;
            draws_q       <= draws_d;
`endif
        end
    end

    assign ROUND       = round_q;
    assign ROUND_VALID = round_valid_q;
    assign GAME        = game_q;
    assign PLAYED      = played_q;
    assign ADV         = adv_q;
`ifdef MORRA_SCORE_EN
    assign P1_WINS     = p1_wins_q;
    assign P2_WINS     = p2_wins_q;
    assign DRAWS       = draws_q;
`endif

endmodule
